// File: rtl/uart_cmd_parser_pkg.sv
// Shared types, ASCII constants and hex helpers for the UART command parser.
package uart_cmd_parser_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SP1,
    S_ADDR,
    S_DATA,
    S_ISSUE,
    S_DISCARD
  } state_t;

  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_SP = 8'h20;
  localparam logic [7:0] CH_R  = 8'h52;
  localparam logic [7:0] CH_W  = 8'h57;

  // Mask that folds lower-case ASCII letters onto upper case.
  localparam logic [7:0] CASE_MASK = 8'hDF;

  function automatic logic is_hex(input logic [7:0] b);
    return ((b >= 8'h30) && (b <= 8'h39)) ||
           ((b >= 8'h41) && (b <= 8'h46)) ||
           ((b >= 8'h61) && (b <= 8'h66));
  endfunction

  // Valid only when is_hex(b); letters map via their low nibble (A/a = 1) + 9.
  function automatic logic [3:0] hex_nibble(input logic [7:0] b);
    if (b <= 8'h39) return b[3:0];
    else            return b[3:0] + 4'd9;
  endfunction

endpackage

// File: rtl/uart_cmd_parser.sv
// Parses "R <hex>\n" / "W <hex> <hex>\n" lines from a UART byte stream
// into read/write commands with a valid/ready handshake.
module uart_cmd_parser
  import uart_cmd_parser_pkg::*;
#(
  parameter int unsigned MAX_DIGITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_ready,
  input  logic [7:0]  i_data,
  output logic        o_cmd_valid,
  input  logic        i_cmd_ready,
  output logic        o_cmd_we,
  output logic [31:0] o_cmd_addr,
  output logic [31:0] o_cmd_wdata,
  output logic        o_err,
  output logic        o_busy
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_DIGITS);

  state_t      state, state_n;
  logic        we_n, err_n;
  logic [31:0] addr_n, wdata_n;
  logic [3:0]  count, count_n;
  logic        byte_ok, is_letter_r, is_letter_w;

  assign byte_ok     = i_ready && (i_data != CH_CR);
  assign is_letter_r = (i_data & CASE_MASK) == CH_R;
  assign is_letter_w = (i_data & CASE_MASK) == CH_W;

  // Next-state, accumulator and error-pulse decode for one received byte.
  always_comb begin
    state_n = state;
    we_n    = o_cmd_we;
    addr_n  = o_cmd_addr;
    wdata_n = o_cmd_wdata;
    count_n = count;
    err_n   = 1'b0;
    case (state)
      S_IDLE: begin
        if (byte_ok) begin
          if (is_letter_r || is_letter_w) begin
            we_n    = is_letter_w;
            addr_n  = '0;
            wdata_n = '0;
            count_n = '0;
            state_n = S_SP1;
          end else if (i_data != CH_LF) begin
            err_n = 1'b1;
          end
        end
      end
      S_SP1: begin
        if (byte_ok) begin
          if (i_data == CH_SP) state_n = S_ADDR;
          else                 err_n   = 1'b1;
        end
      end
      S_ADDR: begin
        if (byte_ok) begin
          if (is_hex(i_data)) begin
            if (count == MAX_CNT) begin
              err_n = 1'b1;
            end else begin
              addr_n  = {o_cmd_addr[27:0], hex_nibble(i_data)};
              count_n = count + 4'd1;
            end
          end else if ((i_data == CH_SP) && o_cmd_we && (count != '0)) begin
            count_n = '0;
            state_n = S_DATA;
          end else if ((i_data == CH_LF) && !o_cmd_we && (count != '0)) begin
            state_n = S_ISSUE;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (byte_ok) begin
          if (is_hex(i_data)) begin
            if (count == MAX_CNT) begin
              err_n = 1'b1;
            end else begin
              wdata_n = {o_cmd_wdata[27:0], hex_nibble(i_data)};
              count_n = count + 4'd1;
            end
          end else if ((i_data == CH_LF) && (count != '0)) begin
            state_n = S_ISSUE;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (i_cmd_ready) state_n = S_IDLE;
        if (byte_ok)     err_n   = 1'b1;
      end
      S_DISCARD: begin
        if (byte_ok && (i_data == CH_LF)) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    // Parse errors abandon the line. An error raised by the LF itself has
    // already consumed the terminator, so resume in IDLE instead of DISCARD.
    if (err_n && (state != S_ISSUE)) begin
      state_n = (i_data == CH_LF) ? S_IDLE : S_DISCARD;
    end
  end

  // State register plus registered command, error and busy outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      o_cmd_we    <= 1'b0;
      o_cmd_addr  <= '0;
      o_cmd_wdata <= '0;
      count       <= '0;
      o_err       <= 1'b0;
      o_cmd_valid <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      state       <= state_n;
      o_cmd_we    <= we_n;
      o_cmd_addr  <= addr_n;
      o_cmd_wdata <= wdata_n;
      count       <= count_n;
      o_err       <= err_n;
      o_cmd_valid <= (state_n == S_ISSUE);
      o_busy      <= (state_n != S_IDLE);
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: a line-level reference model predicts
// commands and error pulses; a monitor pops and checks on each handshake.
module tb_uart_cmd_parser;

  localparam int MAXD = 8;

  typedef byte unsigned bq_t[$];
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_ready = 1'b0;
  logic [7:0]  i_data = '0;
  logic        i_cmd_ready = 1'b0;
  logic        o_cmd_valid, o_cmd_we, o_err, o_busy;
  logic [31:0] o_cmd_addr, o_cmd_wdata;

  int   tests = 0;
  int   fails = 0;
  int   err_seen = 0;
  int   err_exp = 0;
  cmd_t exp_q[$];

  uart_cmd_parser #(.MAX_DIGITS(MAXD)) dut (
    .clk(clk), .rst(rst), .i_ready(i_ready), .i_data(i_data),
    .o_cmd_valid(o_cmd_valid), .i_cmd_ready(i_cmd_ready),
    .o_cmd_we(o_cmd_we), .o_cmd_addr(o_cmd_addr), .o_cmd_wdata(o_cmd_wdata),
    .o_err(o_err), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // ---------------- reference model (whole-line grammar) ----------------
  function automatic int hexval(input byte unsigned c);
    if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
    if (c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
    if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
    return -1;
  endfunction

  function automatic void scan_field(input bq_t q, inout int pos, output longint v, output int n);
    v = 0;
    n = 0;
    while (pos < q.size() && hexval(q[pos]) >= 0) begin
      v = v * 16 + longint'(hexval(q[pos]));
      n++;
      pos++;
    end
  endfunction

  function automatic void ref_line(input bq_t line, output int err, output bit cmd, output cmd_t c);
    bq_t q;
    int pos, n;
    longint v;
    byte unsigned c0;
    foreach (line[i]) if (line[i] != 8'h0D && line[i] != 8'h0A) q.push_back(line[i]);
    err = 0;
    cmd = 0;
    c = '0;
    if (q.size() == 0) return;
    err = 1;
    c0 = q[0] & 8'hDF;
    if (c0 != 8'h52 && c0 != 8'h57) return;
    c.we = (c0 == 8'h57);
    if (q.size() < 2 || q[1] != 8'h20) return;
    pos = 2;
    scan_field(q, pos, v, n);
    if (n < 1 || n > MAXD) return;
    c.addr = v[31:0];
    if (!c.we) begin
      if (pos == q.size()) begin err = 0; cmd = 1; end
      return;
    end
    if (pos >= q.size() || q[pos] != 8'h20) return;
    pos++;
    scan_field(q, pos, v, n);
    if (n < 1 || n > MAXD) return;
    c.wdata = v[31:0];
    if (pos == q.size()) begin err = 0; cmd = 1; end
  endfunction

  function automatic bq_t str2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  initial begin
    cmd_t held, got, e;
    logic was_valid;
    was_valid = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (o_err) err_seen++;
      if (!rst && o_cmd_valid) begin
        got = {o_cmd_we, o_cmd_addr, o_cmd_wdata};
        if (was_valid) chk("hold_stable", got[63:32] ^ held[63:32] | {31'd0, got.we ^ held.we} | (got.wdata ^ held.wdata), 32'd0);
        held = got;
        if (i_cmd_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_cmd", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("cmd_we", {31'd0, got.we}, {31'd0, e.we});
            chk("cmd_addr", got.addr, e.addr);
            chk("cmd_wdata", got.wdata, e.wdata);
          end
          was_valid = 1'b0;
        end else begin
          was_valid = 1'b1;
        end
      end else begin
        was_valid = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_byte(input byte unsigned b);
    i_ready = 1'b1;
    i_data  = b;
    @(posedge clk); #1;
    i_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Sends one line; for a good command holds i_cmd_ready low for `hold`
  // cycles, optionally strobing a junk byte while the command is pending.
  task automatic send_line(input bq_t q, input int hold, input bit junk, input bit gaps);
    int e, ja;
    bit cmd;
    cmd_t c;
    ref_line(q, e, cmd, c);
    err_exp += e;
    if (cmd) exp_q.push_back(c);
    foreach (q[i]) begin
      send_byte(q[i]);
      if (gaps && i != q.size() - 1) idle($urandom_range(0, 2));
    end
    chk("latency_valid", {31'd0, o_cmd_valid}, {31'd0, cmd});
    if (cmd) begin
      ja = $urandom_range(0, hold);
      for (int k = 0; k <= hold; k++) begin
        i_cmd_ready = (k == hold);
        i_ready     = junk && (k == ja);
        i_data      = 8'($urandom_range(33, 126));
        if (junk && k == ja) err_exp++;
        @(posedge clk); #1;
      end
      i_cmd_ready = 1'b0;
      i_ready     = 1'b0;
      chk("post_hs_valid", {31'd0, o_cmd_valid}, 32'd0);
      chk("post_hs_busy", {31'd0, o_busy}, 32'd0);
    end
    idle(2);
    chk("err_count", err_seen, err_exp);
  endtask

  task automatic do_reset(input bit strobe);
    rst     = 1'b1;
    i_ready = strobe;
    i_data  = 8'h52;
    @(posedge clk); #1;
    rst     = 1'b0;
    i_ready = 1'b0;
    chk("rst_valid", {31'd0, o_cmd_valid}, 32'd0);
    chk("rst_we", {31'd0, o_cmd_we}, 32'd0);
    chk("rst_addr", o_cmd_addr, 32'd0);
    chk("rst_wdata", o_cmd_wdata, 32'd0);
    chk("rst_err", {31'd0, o_err}, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
  endtask

  task automatic make_random(output bq_t q);
    string letters, hexs;
    int n;
    letters = "RrWw";
    hexs = "0123456789abcdefABCDEF";
    q = {};
    if ($urandom_range(0, 15) != 0) begin
      q.push_back(letters[$urandom_range(0, 3)]);
      q.push_back(8'h20);
      for (int f = 0; f < ((q[0] & 8'hDF) == 8'h57 ? 2 : 1); f++) begin
        if (f == 1) q.push_back(8'h20);
        n = ($urandom_range(0, 9) == 0) ? 9 : int'($urandom_range(1, 8));
        for (int d = 0; d < n; d++) q.push_back(hexs[$urandom_range(0, 21)]);
      end
      if ($urandom_range(0, 4) == 0) q[$urandom_range(0, q.size() - 1)] = 8'($urandom_range(33, 126));
    end
    if ($urandom_range(0, 3) == 0) q.push_back(8'h0D);
    q.push_back(8'h0A);
  endtask

  initial begin
    bq_t q;
    repeat (3) @(posedge clk);
    #1;
    do_reset(1'b0);

    send_line(str2q("R 1000\n"), 2, 0, 0);
    send_line(str2q("w DEADbeef 12345678\r\n"), 5, 0, 0);
    send_line(str2q("R 123456789\n"), 1, 0, 0);
    send_line(str2q("R 4\n"), 1, 0, 0);
    send_line(str2q("W 10\n"), 1, 0, 0);
    send_line(str2q("X\n"), 1, 0, 0);
    send_line(str2q("R\n"), 1, 0, 0);
    chk("idle_after_errs", {31'd0, o_busy}, 32'd0);
    send_line(str2q("R 8\n"), 3, 1, 0);

    q = str2q("W 12 3");
    foreach (q[i]) send_byte(q[i]);
    do_reset(1'b0);
    send_line(str2q("R 2\n"), 1, 0, 0);

    do_reset(1'b1);
    send_line(str2q(" 5\n"), 1, 0, 0);

    q = str2q("R 7\n");
    foreach (q[i]) send_byte(q[i]);
    chk("issue_before_rst", {31'd0, o_cmd_valid}, 32'd1);
    idle(2);
    do_reset(1'b0);
    idle(2);
    chk("err_after_issue_rst", err_seen, err_exp);

    for (int n = 0; n < 150; n++) begin
      make_random(q);
      send_line(q, $urandom_range(0, 4), ($urandom_range(0, 3) == 0), 1);
    end

    idle(3);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
